// File: rtl/mcu_row_scheduler.sv
// Hands each completed 8-line MCU row in the double-buffered EBR banks to the JPEG encoder, one read job per MCU.
// Latency: bank full -> mcu_req 1 cycle, release -> next issue 2 cycles; jobs hold stable while mcu_req && !mcu_ack.
// MCU_SCHED_PREFETCH_EN allows two jobs in flight; otherwise strictly one job outstanding.
module mcu_row_scheduler #(
    parameter int WIDTH_MCU  = 40,
    parameter int HEIGHT_MCU = 30,
    parameter int NUM_EBR    = 5,
    parameter int EBR_SIZE   = 512
) (
    input  logic                          clock,
    input  logic                          nreset,
    input  logic                          ingest_frontbuffer_select,
    output logic                          mcu_req,
    input  logic                          mcu_ack,
    input  logic                          mcu_done,
    output logic                          rd_bank,
    output logic [$clog2(NUM_EBR)-1:0]    rd_block_select,
    output logic [$clog2(EBR_SIZE)-1:0]   rd_base_addr,
    output logic [$clog2(WIDTH_MCU)-1:0]  mcu_index,
    output logic [$clog2(HEIGHT_MCU)-1:0] row_index,
    output logic                          frame_done,
    output logic                          overrun,
    output logic [1:0]                    bank_full
);

    localparam int BW = $clog2(NUM_EBR);
    localparam int AW = $clog2(EBR_SIZE);
    localparam int MW = $clog2(WIDTH_MCU);
    localparam int RW = $clog2(HEIGHT_MCU);

    localparam logic [BW-1:0] BLK_LAST  = BW'(NUM_EBR - 1);
    localparam logic [MW-1:0] MCU_LAST  = MW'(WIDTH_MCU - 1);
    localparam logic [RW-1:0] ROW_LAST  = RW'(HEIGHT_MCU - 1);
    localparam logic [AW-1:0] BASE_STEP = AW'(64);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RELEASE
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic       fsel_prev;
    logic       toggle;
    logic       accept;
    logic       release_row;
    logic       last_acked;
    logic [1:0] bank_set;
    logic [1:0] bank_clr;

`ifdef MCU_SCHED_PREFETCH_EN
    logic [1:0] outstanding;
    logic       done_valid;

    // A done with nothing in flight is stray and must not underflow the count.
    assign done_valid = mcu_done && (outstanding != 2'd0);
`endif

    assign toggle   = (ingest_frontbuffer_select != fsel_prev);
    assign accept   = mcu_req && mcu_ack;
    assign bank_set = toggle ? (2'b01 << fsel_prev) : 2'b00;
    assign bank_clr = release_row ? (2'b01 << rd_bank) : 2'b00;

    always_comb begin
        state_nxt   = state;
        mcu_req     = 1'b0;
        frame_done  = 1'b0;
        release_row = 1'b0;
        case (state)
            S_IDLE: begin
                if (bank_full[rd_bank]) begin
                    state_nxt = S_ISSUE;
                end
            end
`ifdef MCU_SCHED_PREFETCH_EN
            // Issue and wait merged: keep offering until two jobs are in flight.
            S_ISSUE: begin
                mcu_req = !last_acked && (outstanding != 2'd2);
                if (last_acked && (outstanding == 2'd0)) begin
                    state_nxt = S_RELEASE;
                end
            end
`else
            S_ISSUE: begin
                mcu_req = 1'b1;
                if (mcu_ack) begin
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (mcu_done) begin
                    state_nxt = last_acked ? S_RELEASE : S_ISSUE;
                end
            end
`endif
            S_RELEASE: begin
                release_row = 1'b1;
                frame_done  = (row_index == ROW_LAST);
                state_nxt   = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (nreset) begin
            state           <= S_IDLE;
            fsel_prev       <= ingest_frontbuffer_select;
            bank_full       <= 2'b00;
            overrun         <= 1'b0;
            rd_bank         <= 1'b0;
            rd_block_select <= '0;
            rd_base_addr    <= '0;
            mcu_index       <= '0;
            row_index       <= '0;
            last_acked      <= 1'b0;
`ifdef MCU_SCHED_PREFETCH_EN
            outstanding     <= 2'd0;
`endif
        end else begin
            state     <= state_nxt;
            fsel_prev <= ingest_frontbuffer_select;
            // A new fill on the bank being released wins over the clear.
            bank_full <= (bank_full & ~bank_clr) | bank_set;

            if (toggle && bank_full[ingest_frontbuffer_select]) begin
                overrun <= 1'b1;
            end

            // Block index ripples into the base-address group; no divider needed.
            if (accept) begin
                if (mcu_index == MCU_LAST) begin
                    mcu_index       <= '0;
                    rd_block_select <= '0;
                    rd_base_addr    <= '0;
                    last_acked      <= 1'b1;
                end else begin
                    mcu_index <= mcu_index + 1'b1;
                    if (rd_block_select == BLK_LAST) begin
                        rd_block_select <= '0;
                        rd_base_addr    <= rd_base_addr + BASE_STEP;
                    end else begin
                        rd_block_select <= rd_block_select + 1'b1;
                    end
                end
            end

            if (release_row) begin
                rd_bank    <= ~rd_bank;
                last_acked <= 1'b0;
                row_index  <= (row_index == ROW_LAST) ? '0 : row_index + 1'b1;
            end

`ifdef MCU_SCHED_PREFETCH_EN
            outstanding <= outstanding + {1'b0, accept} - {1'b0, done_valid};
`endif
        end
    end

endmodule

// File: tb/tb_mcu_row_scheduler.sv
// Scoreboard bench for mcu_row_scheduler: expected jobs are queued when a bank fill is driven
// and popped as the encoder model accepts each offered job.
module tb_mcu_row_scheduler;

    logic       clock = 1'b0;
    logic       nreset = 1'b1;
    logic       fsel = 1'b0;
    logic       mcu_ack = 1'b0;
    logic       mcu_done = 1'b0;
    logic       mcu_req;
    logic       rd_bank;
    logic [2:0] rd_block_select;
    logic [8:0] rd_base_addr;
    logic [5:0] mcu_index;
    logic [4:0] row_index;
    logic       frame_done;
    logic       overrun;
    logic [1:0] bank_full;

    typedef struct packed {
        logic       bank;
        logic [2:0] blk;
        logic [8:0] base;
        logic [5:0] mcu;
        logic [4:0] row;
    } job_t;

    job_t exp_q[$];
    int   n_checks  = 0;
    int   n_pass    = 0;
    int   fd_pulses = 0;

    mcu_row_scheduler dut (
        .clock                     (clock),
        .nreset                    (nreset),
        .ingest_frontbuffer_select (fsel),
        .mcu_req                   (mcu_req),
        .mcu_ack                   (mcu_ack),
        .mcu_done                  (mcu_done),
        .rd_bank                   (rd_bank),
        .rd_block_select           (rd_block_select),
        .rd_base_addr              (rd_base_addr),
        .mcu_index                 (mcu_index),
        .row_index                 (row_index),
        .frame_done                (frame_done),
        .overrun                   (overrun),
        .bank_full                 (bank_full)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (frame_done === 1'b1) fd_pulses++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, passed=%0d total=%0d", n_pass, n_checks);
        $fatal(1);
    end

    // Reference addressing uses real mod/div, independent of the DUT's ripple counters.
    task automatic expect_row(input logic bank, input int row);
        job_t e;
        for (int j = 0; j < 40; j++) begin
            e.bank = bank;
            e.blk  = 3'(j % 5);
            e.base = 9'((j / 5) * 64);
            e.mcu  = 6'(j);
            e.row  = 5'(row);
            exp_q.push_back(e);
        end
    endtask

    // Flip the front buffer: the bank the ingester just left becomes full.
    task automatic toggle_fill(input int row);
        expect_row(fsel, row);
        fsel = ~fsel;
    endtask

    task automatic wait_req(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (mcu_req === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clock);
        end
        if (!ok) begin
            n_checks++;
            $display("FAIL req_timeout: mcu_req=%b after 50 cycles, want 1", mcu_req);
        end
    endtask

    task automatic drain_jobs(input int count);
        bit   ok;
        job_t got;
        job_t e;
        for (int k = 0; k < count; k++) begin
            wait_req(ok);
            if (!ok) return;
            got = {rd_bank, rd_block_select, rd_base_addr, mcu_index, row_index};
            n_checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL job_unexpected: got idx=%0d with empty scoreboard, want none", mcu_index);
            end else begin
                e = exp_q.pop_front();
                if (got !== e)
                    $display("FAIL job: got bank=%0d blk=%0d base=%0d idx=%0d row=%0d want bank=%0d blk=%0d base=%0d idx=%0d row=%0d",
                             got.bank, got.blk, got.base, got.mcu, got.row, e.bank, e.blk, e.base, e.mcu, e.row);
                else
                    n_pass++;
            end
            mcu_ack = 1'b1;
            @(negedge clock);
            mcu_ack = 1'b0;
            repeat (k % 3) @(negedge clock);
            mcu_done = 1'b1;
            @(negedge clock);
            mcu_done = 1'b0;
        end
    endtask

    task automatic finish_row(input logic old_bank, input int exp_row);
        for (int i = 0; i < 20; i++) begin
            if (rd_bank !== old_bank) break;
            @(negedge clock);
        end
        n_checks++;
        if (rd_bank !== ~old_bank) $display("FAIL release_bank: rd_bank=%b want %b", rd_bank, ~old_bank);
        else n_pass++;
        n_checks++;
        if (bank_full[old_bank] !== 1'b0) $display("FAIL release_clear: bank_full=%b want bit %0d clear", bank_full, old_bank);
        else n_pass++;
        n_checks++;
        if (row_index !== 5'(exp_row)) $display("FAIL release_row: row_index=%0d want %0d", row_index, exp_row);
        else n_pass++;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clock);
        nreset = 1'b0;
        n_checks++;
        if (mcu_req !== 1'b0) $display("FAIL reset_req: mcu_req=%b want 0", mcu_req);
        else n_pass++;
        n_checks++;
        if (bank_full !== 2'b00) $display("FAIL reset_full: bank_full=%b want 00", bank_full);
        else n_pass++;
        n_checks++;
        if ({overrun, frame_done, rd_bank} !== 3'b000)
            $display("FAIL reset_flags: overrun=%b frame_done=%b rd_bank=%b want 0", overrun, frame_done, rd_bank);
        else n_pass++;
        n_checks++;
        if ({rd_block_select, rd_base_addr, mcu_index, row_index} !== 23'd0)
            $display("FAIL reset_idx: blk=%0d base=%0d idx=%0d row=%0d want 0", rd_block_select, rd_base_addr, mcu_index, row_index);
        else n_pass++;
        @(negedge clock);
        n_checks++;
        if (mcu_req !== 1'b0) $display("FAIL reset_idle: mcu_req=%b want 0 with no bank full", mcu_req);
        else n_pass++;
    endtask

    task automatic test_fill_latency();
        toggle_fill(0);
        @(negedge clock);
        n_checks++;
        if (bank_full !== 2'b01 || mcu_req !== 1'b0)
            $display("FAIL fill_detect: bank_full=%b mcu_req=%b want 01/0", bank_full, mcu_req);
        else n_pass++;
        @(negedge clock);
        n_checks++;
        if ({mcu_req, rd_bank, rd_block_select, rd_base_addr} !== 14'b1_0_000_000000000)
            $display("FAIL first_req: req=%b bank=%b blk=%0d base=%0d want 1/0/0/0", mcu_req, rd_bank, rd_block_select, rd_base_addr);
        else n_pass++;
    endtask

    task automatic test_hold_ack();
        for (int i = 0; i < 10; i++) begin
            n_checks++;
            if ({mcu_req, rd_block_select, rd_base_addr, mcu_index} !== 19'b1_000_000000000_000000)
                $display("FAIL hold_stable: cycle=%0d req=%b blk=%0d base=%0d idx=%0d want 1/0/0/0",
                         i, mcu_req, rd_block_select, rd_base_addr, mcu_index);
            else n_pass++;
            @(negedge clock);
        end
    endtask

    task automatic test_drain_row();
        drain_jobs(40);
        finish_row(1'b0, 1);
    endtask

    task automatic test_frame();
        for (int r = 1; r < 30; r++) begin
            toggle_fill(r);
            drain_jobs(40);
            if (r == 28) begin
                n_checks++;
                if (fd_pulses !== 0) $display("FAIL frame_early: frame_done pulses=%0d want 0 before row 29", fd_pulses);
                else n_pass++;
            end
            finish_row(1'(r % 2), (r + 1) % 30);
        end
        n_checks++;
        if (fd_pulses !== 1) $display("FAIL frame_done: pulses=%0d want 1", fd_pulses);
        else n_pass++;
        n_checks++;
        if (frame_done !== 1'b0 || overrun !== 1'b0)
            $display("FAIL frame_after: frame_done=%b overrun=%b want 0/0", frame_done, overrun);
        else n_pass++;
    endtask

    task automatic test_overrun();
        toggle_fill(0);
        drain_jobs(3);
        n_checks++;
        if (overrun !== 1'b0) $display("FAIL overrun_early: overrun=%b want 0", overrun);
        else n_pass++;
        toggle_fill(1);
        @(negedge clock);
        n_checks++;
        if (overrun !== 1'b1) $display("FAIL overrun_set: overrun=%b want 1", overrun);
        else n_pass++;
        drain_jobs(37);
        finish_row(1'b0, 1);
        drain_jobs(40);
        finish_row(1'b1, 2);
        n_checks++;
        if (overrun !== 1'b1) $display("FAIL overrun_sticky: overrun=%b want 1", overrun);
        else n_pass++;
    endtask

    task automatic test_reset_mid_wait();
        bit ok;
        toggle_fill(2);
        wait_req(ok);
        mcu_ack = 1'b1;
        @(negedge clock);
        mcu_ack = 1'b0;
        @(negedge clock);
        nreset = 1'b1;
        fsel   = 1'b0;
        @(negedge clock);
        nreset = 1'b0;
        exp_q.delete();
        n_checks++;
        if ({mcu_req, rd_bank, rd_block_select, rd_base_addr, mcu_index, row_index, frame_done, overrun, bank_full} !== 29'd0)
            $display("FAIL reset_mid: req=%b bank=%b blk=%0d base=%0d idx=%0d row=%0d fd=%b ovr=%b full=%b want all 0",
                     mcu_req, rd_bank, rd_block_select, rd_base_addr, mcu_index, row_index, frame_done, overrun, bank_full);
        else n_pass++;
        mcu_done = 1'b1;
        @(negedge clock);
        mcu_done = 1'b0;
        repeat (3) @(negedge clock);
        n_checks++;
        if ({mcu_req, rd_bank, rd_block_select, rd_base_addr, mcu_index, row_index, frame_done, overrun, bank_full} !== 29'd0)
            $display("FAIL stray_done: req=%b bank=%b blk=%0d base=%0d idx=%0d row=%0d fd=%b ovr=%b full=%b want all 0",
                     mcu_req, rd_bank, rd_block_select, rd_base_addr, mcu_index, row_index, frame_done, overrun, bank_full);
        else n_pass++;
        toggle_fill(0);
        drain_jobs(40);
        finish_row(1'b0, 1);
    endtask

    initial begin
        test_reset();
        test_fill_latency();
        test_hold_ack();
        test_drain_row();
        test_frame();
        test_overrun();
        test_reset_mid_wait();
        n_checks++;
        if (exp_q.size() != 0) $display("FAIL scoreboard_left: %0d jobs never offered, want 0", exp_q.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
